pixel_rescaler: RTL

//  Final stage of the edge-detection datapath, downstream of the min/max search.

---
 rtl/rescaler_pkg.sv | 32 +++
 rtl/serial_divider.sv | 79 +++++++
 rtl/pixel_rescaler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rescaler_pkg.sv
// Shared constants and state encoding for the pixel rescaler.
//   NB_PIXEL    width of signed convolution results and min/max values
//   NB_COUNT    width of the image-size / pixel counter
//   NB_OUT      output pixel width; full scale is 2^NB_OUT-1
//   NB_FRAC     fractional bits of the fixed-point scale factor
//   NB_SCALE    scale factor width (integer part NB_OUT + NB_FRAC fraction)
//   NB_RANGE    width of max-min and of the clamped offset x-min
//   NB_PROD     width of the offset * scale product
//   FULL_SCALE  largest output pixel value
//   ROUND_CONST half an LSB of the output, added before truncation
//   PIPE_LAT    cycles from accepted input to output pixel
package rescaler_pkg;

    localparam int NB_PIXEL    = 19;
    localparam int NB_COUNT    = 32;
    localparam int NB_OUT      = 8;
    localparam int NB_FRAC     = 16;
    localparam int NB_SCALE    = NB_OUT + NB_FRAC;
    localparam int NB_RANGE    = NB_PIXEL + 1;
    localparam int NB_PROD     = NB_RANGE + NB_SCALE;
    localparam int FULL_SCALE  = (1 << NB_OUT) - 1;
    localparam int ROUND_CONST = 1 << (NB_FRAC - 1);
    localparam int PIPE_LAT    = 3;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t DIV   = 2'd1;
    localparam state_t RUN   = 2'd2;
    localparam state_t DRAIN = 2'd3;

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle.
//   clock     in   clock, all logic on posedge
//   reset     in   asynchronous active-low reset
//   start     in   pulse: latch dividend/divisor and begin dividing
//   dividend  in   NB_DIVIDEND-bit unsigned dividend
//   divisor   in   NB_DIVISOR-bit unsigned divisor (must be non-zero)
//   done      out  one-cycle pulse when quotient is valid
//   quotient  out  floor(dividend/divisor), valid while done is high
// The dividend register doubles as the quotient register: each step shifts one dividend
// bit out of the top into the partial remainder and one quotient bit in at the bottom.
module serial_divider #(
    parameter int NB_DIVIDEND = 24,
    parameter int NB_DIVISOR  = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NB_DIVIDEND-1:0] dividend,
    input  logic [NB_DIVISOR-1:0]  divisor,
    output logic                   done,
    output logic [NB_DIVIDEND-1:0] quotient
);

    localparam int                NB_CNT   = $clog2(NB_DIVIDEND + 1);
    localparam logic [NB_CNT-1:0] CNT_INIT = NB_CNT'(NB_DIVIDEND);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    logic [NB_DIVISOR-1:0]  divisor_q;
    logic [NB_DIVISOR-1:0]  rem_q;
    logic [NB_DIVISOR-1:0]  rem_d;
    logic [NB_DIVIDEND-1:0] quo_q;
    logic [NB_DIVIDEND-1:0] quo_d;
    logic [NB_CNT-1:0]      cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [NB_DIVISOR:0]    rem_shift;
    logic [NB_DIVISOR:0]    trial;
    logic                   fits;

    // The partial remainder is always below the divisor, so rem_shift < 2*divisor and
    // the MSB of the trial subtraction is a pure borrow flag.
    always_comb begin
        rem_shift = {rem_q, quo_q[NB_DIVIDEND-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        fits      = ~trial[NB_DIVISOR];
        rem_d     = fits ? trial[NB_DIVISOR-1:0] : rem_shift[NB_DIVISOR-1:0];
        quo_d     = {quo_q[NB_DIVIDEND-2:0], fits};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (start) begin
            divisor_q <= divisor;
            rem_q     <= '0;
            quo_q     <= dividend;
            cnt_q     <= CNT_INIT;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q - CNT_ONE;
            busy_q <= (cnt_q != CNT_ONE);
            done_q <= (cnt_q == CNT_ONE);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/pixel_rescaler.sv
// Final edge-detection stage: maps signed convolution results onto 8-bit pixels using
// round((x-min)*255/(max-min)), clamped to 0..255. The fixed-point scale is computed once
// per frame by a serial divider, then pixels stream through a 3-stage pipeline.
//   clock        in   single clock, all logic on posedge
//   reset        in   asynchronous active-low reset, clears all state
//   i_start      in   pulse in IDLE: latch min/max/size and compute the scale
//   i_minValue   in   signed image minimum
//   i_maxValue   in   signed image maximum
//   i_imageSize  in   number of pixels in the frame
//   i_valid      in   i_convValue valid (accepted only while o_ready)
//   i_convValue  in   signed convolution result
//   o_ready      out  high in RUN only
//   o_valid      out  o_pixel valid, PIPE_LAT cycles after the accepted input
//   o_pixel      out  rescaled pixel, holds its value while o_valid is low
//   o_busy       out  high in every state except IDLE
//   o_done       out  one-cycle pulse once the last pixel has left the pipeline
module pixel_rescaler
    import rescaler_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic signed [NB_PIXEL-1:0] i_minValue,
    input  logic signed [NB_PIXEL-1:0] i_maxValue,
    input  logic        [NB_COUNT-1:0] i_imageSize,
    input  logic                       i_valid,
    input  logic signed [NB_PIXEL-1:0] i_convValue,
    output logic                       o_ready,
    output logic                       o_valid,
    output logic        [NB_OUT-1:0]   o_pixel,
    output logic                       o_busy,
    output logic                       o_done
);

    // 255 in Q8.16: the scale is this divided by the pixel range.
    localparam logic [NB_SCALE-1:0] DIVIDEND  = NB_SCALE'(FULL_SCALE << NB_FRAC);
    localparam logic [NB_COUNT-1:0] COUNT_ONE = NB_COUNT'(1);

    state_t              state_q;
    state_t              state_d;
    logic                start_ok;
    logic                accept;
    logic                div_start;
    logic                div_done;
    logic                pipe_empty;
    logic [NB_SCALE-1:0] quotient;

    logic [NB_PIXEL-1:0] min_q;
    logic [NB_RANGE-1:0] range_q;
    logic [NB_COUNT-1:0] size_q;
    logic [NB_COUNT-1:0] count_q;
    logic [NB_COUNT-1:0] count_inc;
    logic [NB_SCALE-1:0] scale_q;

    logic [NB_RANGE-1:0] span;
    logic [NB_RANGE-1:0] range_in;

    logic [NB_RANGE-1:0] x_ext;
    logic [NB_RANGE-1:0] diff;
    logic [NB_RANGE-1:0] d_clamp;
    logic [NB_RANGE-1:0] d_q;
    logic [PIPE_LAT-1:0] pipe_v_q;
    logic [NB_PROD-1:0]  prod_q;
    logic [NB_PROD-1:0]  rounded;
    logic [NB_OUT-1:0]   pixel_d;
    logic [NB_OUT-1:0]   pixel_q;
    logic                unused_round_lsbs;

    // ---------------------------------------------------------------- control

    assign start_ok  = i_start && (state_q == IDLE);
    assign accept    = i_valid && (state_q == RUN);
    assign count_inc = count_q + COUNT_ONE;
    assign pipe_empty = (pipe_v_q == '0);

    // max-min with one extra bit so the full signed span fits; max <= min gives range 0.
    assign span     = {i_maxValue[NB_PIXEL-1], i_maxValue} - {i_minValue[NB_PIXEL-1], i_minValue};
    assign range_in = (span[NB_RANGE-1] || (span == '0)) ? '0 : span;

    // A zero range never starts the divider: the scale stays 0 and DIV lasts one cycle.
    assign div_start = start_ok && (range_in != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = DIV;
            end
            DIV: begin
                if ((range_q == '0) || div_done) begin
                    state_d = (size_q == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept && (count_inc == size_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            min_q   <= '0;
            range_q <= '0;
            size_q  <= '0;
            count_q <= '0;
            scale_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                min_q   <= i_minValue;
                range_q <= range_in;
                size_q  <= i_imageSize;
                count_q <= '0;
                scale_q <= '0;
            end else begin
                if (accept) count_q <= count_inc;
                if ((state_q == DIV) && div_done) scale_q <= quotient;
            end
        end
    end

    serial_divider #(
        .NB_DIVIDEND (NB_SCALE),
        .NB_DIVISOR  (NB_RANGE)
    ) u_divider (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (range_in),
        .done     (div_done),
        .quotient (quotient)
    );

    // ---------------------------------------------------------------- datapath

    // S1: offset from the minimum, clamped into 0..range.
    always_comb begin
        x_ext = {i_convValue[NB_PIXEL-1], i_convValue};
        diff  = x_ext - {min_q[NB_PIXEL-1], min_q};
        if (diff[NB_RANGE-1]) begin
            d_clamp = '0;
        end else if (diff > range_q) begin
            d_clamp = range_q;
        end else begin
            d_clamp = diff;
        end
    end

    // S3: round to nearest, then saturate anything above full scale.
    always_comb begin
        rounded = prod_q + NB_PROD'(ROUND_CONST);
        if (|rounded[NB_PROD-1:NB_FRAC+NB_OUT]) begin
            pixel_d = NB_OUT'(FULL_SCALE);
        end else begin
            pixel_d = rounded[NB_FRAC+NB_OUT-1:NB_FRAC];
        end
    end

    assign unused_round_lsbs = ^rounded[NB_FRAC-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_v_q <= '0;
            d_q      <= '0;
            prod_q   <= '0;
            pixel_q  <= '0;
        end else begin
            pipe_v_q <= {pipe_v_q[PIPE_LAT-2:0], accept};
            if (accept)      d_q     <= d_clamp;
            if (pipe_v_q[0]) prod_q  <= NB_PROD'(d_q) * NB_PROD'(scale_q);
            if (pipe_v_q[1]) pixel_q <= pixel_d;
        end
    end

    // ---------------------------------------------------------------- outputs

    assign o_ready = (state_q == RUN);
    assign o_valid = pipe_v_q[PIPE_LAT-1];
    assign o_pixel = pixel_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DRAIN) && pipe_empty;

endmodule
